// File: rtl/dbg_trace_buffer_if.sv
// -----------------------------------------------------------------------------
// dbg_trace_buffer_if
//
// Purpose
//   Groups the trace-capture and LED-replay signals of dbg_trace_buffer into
//   one bundle. The producer side (CPU debug trace plus board switches) uses
//   the master modport. The trace buffer uses the slave modport.
//
// Signals (direction seen from the master)
//   clear      out  1     synchronous clear of buffer contents and flags
//   dbg_valid  out  1     one trace entry retires this cycle
//   dbg_inst   out  32    retired instruction word
//   dbg_a      out  32    ALU operand A
//   dbg_b      out  32    ALU operand B
//   dbg_op     out  3     ALU op code
//   freeze     out  1     level: 1 = stop capture and replay the buffer
//   rd_next    out  1     one-cycle pulse: advance replay to the next entry
//   SEL        out  3     LED byte select
//   LED        in   8     registered display byte
//   count      in   AW+1  valid entries held, 0..DEPTH
//   wrapped    in   1     sticky: oldest entry has been overwritten
//   dropped    in   1     sticky: an entry arrived while frozen
//   state_dbg  in   1     FSM state: 0 = capture, 1 = frozen
//
// Handshake
//   There is no backpressure. dbg_valid is a fire-and-forget strobe that is
//   sampled on every rising clock edge. In capture it is always accepted.
//   In frozen it is discarded and recorded in 'dropped'. rd_next is likewise
//   a single-cycle strobe with no ready.
// -----------------------------------------------------------------------------
interface dbg_trace_buffer_if #(
    parameter int AW = 4
);
    logic          clear;
    logic          dbg_valid;
    logic [31:0]   dbg_inst;
    logic [31:0]   dbg_a;
    logic [31:0]   dbg_b;
    logic [2:0]    dbg_op;
    logic          freeze;
    logic          rd_next;
    logic [2:0]    SEL;
    logic [7:0]    LED;
    logic [AW:0]   count;
    logic          wrapped;
    logic          dropped;
    logic          state_dbg;

    modport master (
        output clear,
        output dbg_valid,
        output dbg_inst,
        output dbg_a,
        output dbg_b,
        output dbg_op,
        output freeze,
        output rd_next,
        output SEL,
        input  LED,
        input  count,
        input  wrapped,
        input  dropped,
        input  state_dbg
    );

    modport slave (
        input  clear,
        input  dbg_valid,
        input  dbg_inst,
        input  dbg_a,
        input  dbg_b,
        input  dbg_op,
        input  freeze,
        input  rd_next,
        input  SEL,
        output LED,
        output count,
        output wrapped,
        output dropped,
        output state_dbg
    );
endinterface

// File: rtl/dbg_trace_buffer.sv
// -----------------------------------------------------------------------------
// dbg_trace_buffer
//
// Purpose
//   This block is the consumer end of the CPU debug trace. While capturing,
//   each retired instruction writes one 99-bit entry into a circular buffer:
//     {op[2:0], inst[31:0], a[31:0], b[31:0]}
//   When 'freeze' is raised, capture stops and the buffer is replayed on the
//   board LEDs. The oldest entry comes first. SEL picks which byte of the
//   current entry is shown, and rd_next steps to the next entry.
//
// Parameters
//   DEPTH  entries held (power of two, >= 2)
//   AW     log2(DEPTH), width of the pointer and the replay index
//
// Ports
//   CLK    in      single clock; all state changes on the rising edge
//   RST    in      asynchronous, active-high reset
//   bus    slave   trace / replay bundle (see dbg_trace_buffer_if)
//
// Notes
//   - The RAM has no reset. Only the pointers, the count and the flags are
//     cleared, so entries beyond 'count' are never shown.
//   - LED is registered. Its value is based on SEL, rd_idx and the state as
//     they stood before the previous edge, which gives one cycle of latency.
// -----------------------------------------------------------------------------
module dbg_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              CLK,
    input  logic              RST,
    dbg_trace_buffer_if.slave bus
);

    localparam int          EW      = 99;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic {
        ST_CAPTURE = 1'b0,
        ST_FROZEN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q,   state_d;
    logic [AW-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [AW:0]     count_q,   count_d;
    logic [AW-1:0]   rd_idx_q,  rd_idx_d;
    logic            wrapped_q, wrapped_d;
    logic            dropped_q, dropped_d;
    logic [7:0]      led_q,     led_d;

    logic [EW-1:0]   mem_q [DEPTH];
    logic            wr_en;
    logic [EW-1:0]   wr_entry;

    // ------------------------------------------------------------------
    // Replay read path
    // ------------------------------------------------------------------
    logic [AW-1:0]   rd_addr;
    logic [EW-1:0]   rd_entry;
    logic [AW:0]     last_idx;
    logic [4:0]      count5;
    logic            unused_bits;

    assign wr_entry = {bus.dbg_op, bus.dbg_inst, bus.dbg_a, bus.dbg_b};

    // The oldest entry sits 'count' slots behind the write pointer. When the
    // buffer is full, count[AW-1:0] is 0, so the oldest entry is wr_ptr
    // itself. The modulo DEPTH wrap comes for free from the AW-bit width.
    assign rd_addr  = wr_ptr_q - count_q[AW-1:0] + rd_idx_q;
    assign rd_entry = mem_q[rd_addr];

    // This is the highest replay index. It is only used when count > 0.
    assign last_idx = count_q - (AW+1)'(1);

    // The count field in the capture-mode LED byte is 5 bits wide.
    assign count5   = 5'(count_q);

    // The upper operand bytes are stored but never shown on the LEDs.
    assign unused_bits = ^{rd_entry[63:40], rd_entry[31:8]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        rd_idx_d  = rd_idx_q;
        wrapped_d = wrapped_q;
        dropped_d = dropped_q;
        wr_en     = 1'b0;

        unique case (state_q)
            ST_CAPTURE: begin
                if (bus.dbg_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (count_q < DEPTH_C) begin
                        count_d = count_q + (AW+1)'(1);
                    end else begin
                        wrapped_d = 1'b1;
                    end
                end
                // An entry that retires in the same cycle as freeze is
                // still written above, so it becomes part of the replay.
                if (bus.freeze) begin
                    state_d  = ST_FROZEN;
                    rd_idx_d = '0;
                end
            end

            ST_FROZEN: begin
                if (bus.dbg_valid) begin
                    dropped_d = 1'b1;
                end
                if (bus.rd_next && (count_q != '0)) begin
                    if ({1'b0, rd_idx_q} == last_idx) begin
                        rd_idx_d = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + AW'(1);
                    end
                end
                if (!bus.freeze) begin
                    state_d = ST_CAPTURE;
                end
            end

            default: begin
                state_d = ST_CAPTURE;
            end
        endcase

        // Clear overrides any write or step in the same cycle. It leaves
        // the state unchanged, so a frozen buffer stays frozen but empty.
        if (bus.clear) begin
            wr_en     = 1'b0;
            wr_ptr_d  = '0;
            count_d   = '0;
            rd_idx_d  = '0;
            wrapped_d = 1'b0;
            dropped_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // LED byte (computed from the current registers, then registered)
    // ------------------------------------------------------------------
    always_comb begin
        led_d = 8'h00;
        if (state_q == ST_CAPTURE) begin
            led_d = {1'b0, wrapped_q, dropped_q, count5};
        end else if (count_q != '0) begin
            unique case (bus.SEL)
                3'd0:    led_d = rd_entry[71:64];
                3'd1:    led_d = rd_entry[79:72];
                3'd2:    led_d = rd_entry[87:80];
                3'd3:    led_d = rd_entry[95:88];
                3'd4:    led_d = rd_entry[39:32];
                3'd5:    led_d = rd_entry[7:0];
                3'd6:    led_d = {5'b0, rd_entry[98:96]};
                3'd7:    led_d = 8'(rd_idx_q);
                default: led_d = 8'h00;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_CAPTURE;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            rd_idx_q  <= '0;
            wrapped_q <= 1'b0;
            dropped_q <= 1'b0;
            led_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            rd_idx_q  <= rd_idx_d;
            wrapped_q <= wrapped_d;
            dropped_q <= dropped_d;
            led_q     <= led_d;
        end
    end

    // The trace RAM has no reset, so it can map onto plain memory.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.LED       = led_q;
    assign bus.count     = count_q;
    assign bus.wrapped   = wrapped_q;
    assign bus.dropped   = dropped_q;
    assign bus.state_dbg = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_dbg_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_dbg_trace_buffer
//
// Directed testbench for dbg_trace_buffer. Every expected value is worked out
// by hand from the behaviour of the buffer: the oldest-first replay order,
// the LED byte map, the count/wrapped/dropped rules, clear and async reset.
// Inputs change 1 time unit after each rising edge, and outputs are sampled
// at that same point.
// -----------------------------------------------------------------------------
module tb_dbg_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dbg_trace_buffer_if #(.AW(AW)) bus ();

    dbg_trace_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clear     = 1'b0;
        bus.dbg_valid = 1'b0;
        bus.dbg_inst  = '0;
        bus.dbg_a     = '0;
        bus.dbg_b     = '0;
        bus.dbg_op    = '0;
        bus.freeze    = 1'b0;
        bus.rd_next   = 1'b0;
        bus.SEL       = '0;
    endtask

    task automatic write_entry(input logic [31:0] inst, input logic [31:0] a,
                               input logic [31:0] b, input logic [2:0] op);
        bus.dbg_valid = 1'b1;
        bus.dbg_inst  = inst;
        bus.dbg_a     = a;
        bus.dbg_b     = b;
        bus.dbg_op    = op;
        step();
        bus.dbg_valid = 1'b0;
    endtask

    task automatic pulse_next();
        bus.rd_next = 1'b1;
        step();
        bus.rd_next = 1'b0;
    endtask

    // Selects a byte, lets the LED register load it, then compares.
    task automatic show(input logic [2:0] sel, input logic [7:0] exp, input string tag);
        bus.SEL = sel;
        step();
        chk(tag, 32'(bus.LED), 32'(exp));
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        idle_inputs();

        // Reset values
        step();
        step();
        chk("rst_count",   32'(bus.count),     32'd0);
        chk("rst_led",     32'(bus.LED),       32'h00);
        chk("rst_wrapped", 32'(bus.wrapped),   32'd0);
        chk("rst_dropped", 32'(bus.dropped),   32'd0);
        chk("rst_state",   32'(bus.state_dbg), 32'd0);
        rst = 1'b0;

        // 1. Three writes, freeze, walk SEL over the oldest entry
        write_entry(32'h2008_0005, 32'hA0, 32'hB0, 3'd1);
        write_entry(32'h2009_000A, 32'hA1, 32'hB1, 3'd2);
        write_entry(32'h0109_5020, 32'hA2, 32'hB2, 3'd3);
        chk("t1_capture_led", 32'(bus.LED), 32'h02);   // still shows count before 3rd write
        bus.freeze = 1'b1;
        step();
        chk("t1_count", 32'(bus.count),     32'd3);
        chk("t1_state", 32'(bus.state_dbg), 32'd1);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h20);
        for (int s = 0; s < 4; s++) begin
            show(3'(s), exp_q.pop_front(), "t1_inst_byte");
        end
        show(3'd4, 8'hA0, "t1_a_byte");
        show(3'd5, 8'hB0, "t1_b_byte");
        show(3'd6, 8'h01, "t1_op_byte");
        show(3'd7, 8'h00, "t1_idx0");

        // 2. Step through the replay, wrapping after count-1
        pulse_next();
        show(3'd7, 8'h01, "t2_idx1");
        show(3'd0, 8'h0A, "t2_idx1_inst0");
        show(3'd6, 8'h02, "t2_idx1_op");
        pulse_next();
        show(3'd7, 8'h02, "t2_idx2");
        show(3'd4, 8'hA2, "t2_idx2_a");
        pulse_next();
        show(3'd7, 8'h00, "t2_idx_wrap");
        show(3'd0, 8'h05, "t2_wrap_oldest");

        // 3. Overfill: 20 writes into 16 slots
        bus.freeze = 1'b0;
        rst_pulse();
        for (int k = 0; k < 20; k++) begin
            write_entry(32'(k), 32'(k), 32'(k), 3'd0);
        end
        chk("t3_count",   32'(bus.count),   32'd16);
        chk("t3_wrapped", 32'(bus.wrapped), 32'd1);
        chk("t3_cap_led", 32'(bus.LED),     32'h50);
        bus.freeze = 1'b1;
        step();
        show(3'd0, 8'h04, "t3_oldest");
        for (int k = 0; k < 15; k++) begin
            pulse_next();
        end
        show(3'd0, 8'h13, "t3_newest");
        show(3'd7, 8'h0F, "t3_idx15");
        pulse_next();
        show(3'd7, 8'h00, "t3_idx_wrap");

        // 4. Write coinciding with freeze is kept; a later write is dropped
        bus.freeze = 1'b0;
        rst_pulse();
        write_entry(32'h41, 32'h0, 32'h0, 3'd0);
        bus.freeze = 1'b1;
        write_entry(32'h42, 32'h0, 32'h0, 3'd0);
        chk("t4_count",    32'(bus.count),     32'd2);
        chk("t4_state",    32'(bus.state_dbg), 32'd1);
        chk("t4_drop_pre", 32'(bus.dropped),   32'd0);
        write_entry(32'h43, 32'h0, 32'h0, 3'd0);
        chk("t4_dropped",    32'(bus.dropped), 32'd1);
        chk("t4_count_hold", 32'(bus.count),   32'd2);
        show(3'd0, 8'h41, "t4_idx0");
        pulse_next();
        show(3'd0, 8'h42, "t4_idx1");
        pulse_next();
        show(3'd7, 8'h00, "t4_idx_wrap");
        bus.freeze = 1'b0;
        step();
        step();
        chk("t4_recap_led", 32'(bus.LED), 32'h22);
        write_entry(32'h44, 32'h0, 32'h0, 3'd0);
        chk("t4_append", 32'(bus.count), 32'd3);

        // 5. Empty replay, then clear during replay
        rst_pulse();
        bus.freeze = 1'b1;
        step();
        chk("t5_empty_count", 32'(bus.count), 32'd0);
        pulse_next();
        pulse_next();
        show(3'd7, 8'h00, "t5_empty_idx");
        show(3'd0, 8'h00, "t5_empty_led");
        bus.freeze = 1'b0;
        step();
        write_entry(32'h51, 32'h0, 32'h0, 3'd0);
        write_entry(32'h52, 32'h0, 32'h0, 3'd0);
        write_entry(32'h53, 32'h0, 32'h0, 3'd0);
        bus.freeze = 1'b1;
        step();
        pulse_next();
        show(3'd7, 8'h01, "t5_idx1");
        write_entry(32'h54, 32'h0, 32'h0, 3'd0);
        chk("t5_dropped", 32'(bus.dropped), 32'd1);
        bus.clear   = 1'b1;
        bus.rd_next = 1'b1;
        step();
        bus.clear   = 1'b0;
        bus.rd_next = 1'b0;
        chk("t5_clr_count",   32'(bus.count),     32'd0);
        chk("t5_clr_dropped", 32'(bus.dropped),   32'd0);
        chk("t5_clr_wrapped", 32'(bus.wrapped),   32'd0);
        chk("t5_clr_state",   32'(bus.state_dbg), 32'd1);
        show(3'd0, 8'h00, "t5_clr_led");

        // 6. Asynchronous reset between clock edges
        bus.freeze = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            write_entry(32'h60 + 32'(k), 32'h0, 32'h0, 3'd0);
        end
        chk("t6_count", 32'(bus.count), 32'd5);
        step();
        chk("t6_cap_led", 32'(bus.LED), 32'h05);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_count", 32'(bus.count),     32'd0);
        chk("t6_async_led",   32'(bus.LED),       32'h00);
        chk("t6_async_state", 32'(bus.state_dbg), 32'd0);
        rst = 1'b0;
        step();
        chk("t6_post_count", 32'(bus.count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
